// File: rtl/memory_read_ctrl.sv
// memory_read_ctrl: walks a linked cell chain on memory port B, streams each cell as
// 64-bit beats with begin/end framing and returns consumed cells to the free list.
// Optional footer validity check enabled by defining MEM_RD_FOOTER_CHECK_EN.
module memory_read_ctrl #(
   parameter int  ADDR_W       = 10,
   parameter int  CELL_BEATS   = 7,
   localparam int PAYLOAD_BITS = 64*CELL_BEATS,
   localparam int BLOCK_BITS   = PAYLOAD_BITS + 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   input  logic [ADDR_W-1:0]     req_head_idx_i,
   output logic                  req_ready_o,
   output logic                  mem_re_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   input  logic [BLOCK_BITS-1:0] mem_rdata_i,
   output logic [63:0]           data_o,
   output logic                  data_valid_o,
   output logic                  data_begin_o,
   output logic                  data_end_o,
   input  logic                  data_ready_i,
   output logic                  fl_free_req_o,
   output logic [ADDR_W-1:0]     fl_free_idx_o,
   input  logic                  fl_free_gnt_i,
   output logic                  err_o
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_STREAM, S_FREE, S_ERR} state_e;

   localparam logic [2:0] MAX_BEAT = 3'(CELL_BEATS-1);

   function automatic logic [63:0] beat_sel(input logic [PAYLOAD_BITS-1:0] pl,
                                            input logic [2:0] k);
      return pl[PAYLOAD_BITS-1-64*int'(k) -: 64];
   endfunction

   function automatic logic [2:0] clamp_last(input logic [2:0] lb);
      return (lb > MAX_BEAT) ? MAX_BEAT : lb;
   endfunction

   function automatic logic is_last(input logic eop, input logic [2:0] lb,
                                    input logic [2:0] k);
      return eop ? (k == lb) : (k == MAX_BEAT);
   endfunction

   state_e                  state_q;
   logic [ADDR_W-1:0]       curr_idx_q, next_idx_q, mem_addr_q, fl_free_idx_q;
   logic                    eop_q, first_q;
   logic [2:0]              last_beat_q, beat_cnt_q;
   logic [PAYLOAD_BITS-1:0] payload_q;
   logic [63:0]             data_q;
   logic                    mem_re_q, data_valid_q, data_begin_q, data_end_q;
   logic                    fl_free_req_q, err_q;

   logic [63:0]             footer;
   logic [PAYLOAD_BITS-1:0] rd_payload;
   logic [ADDR_W-1:0]       ft_next;
   logic                    ft_eop, ft_valid, footer_bad, cell_last;
   logic [2:0]              ft_last, beat_nxt;

   assign footer     = mem_rdata_i[63:0];
   assign rd_payload = mem_rdata_i[BLOCK_BITS-1:64];
   assign ft_next    = footer[ADDR_W-1:0];
   assign ft_eop     = footer[ADDR_W];
   assign ft_valid   = footer[ADDR_W+1];
   assign ft_last    = clamp_last(footer[ADDR_W+4:ADDR_W+2]);
   assign beat_nxt   = beat_cnt_q + 3'd1;
   assign cell_last  = is_last(eop_q, last_beat_q, beat_cnt_q);

`ifdef MEM_RD_FOOTER_CHECK_EN
   assign footer_bad = !ft_valid;
   assign err_o      = err_q;
`else
   assign footer_bad = 1'b0;
   assign err_o      = 1'b0;
`endif

   // Reserved footer bits carry no meaning for the reader.
   logic unused_ok;
   assign unused_ok = ^{footer[63:ADDR_W+5], ft_valid, err_q};

   assign req_ready_o   = (state_q == S_IDLE);
   assign mem_re_o      = mem_re_q;
   assign mem_addr_o    = mem_addr_q;
   assign data_o        = data_q;
   assign data_valid_o  = data_valid_q;
   assign data_begin_o  = data_begin_q;
   assign data_end_o    = data_end_q;
   assign fl_free_req_o = fl_free_req_q;
   assign fl_free_idx_o = fl_free_idx_q;

   always_ff @(posedge clk) begin
      if (state_q == S_WAIT) payload_q <= rd_payload;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         curr_idx_q    <= '0;
         next_idx_q    <= '0;
         eop_q         <= 1'b0;
         first_q       <= 1'b0;
         last_beat_q   <= '0;
         beat_cnt_q    <= '0;
         mem_re_q      <= 1'b0;
         mem_addr_q    <= '0;
         data_q        <= '0;
         data_valid_q  <= 1'b0;
         data_begin_q  <= 1'b0;
         data_end_q    <= 1'b0;
         fl_free_req_q <= 1'b0;
         fl_free_idx_q <= '0;
         err_q         <= 1'b0;
      end else begin
         mem_re_q <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  curr_idx_q <= req_head_idx_i;
                  mem_addr_q <= req_head_idx_i;
                  mem_re_q   <= 1'b1;
                  first_q    <= 1'b1;
                  state_q    <= S_READ;
               end
            end
            S_READ: state_q <= S_WAIT;
            S_WAIT: begin
               beat_cnt_q  <= '0;
               next_idx_q  <= ft_next;
               eop_q       <= ft_eop;
               last_beat_q <= ft_last;
               if (footer_bad) begin
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  // Beat 0 is presented straight from the read data.
                  data_q       <= beat_sel(rd_payload, 3'd0);
                  data_valid_q <= 1'b1;
                  data_begin_q <= first_q;
                  data_end_q   <= ft_eop && is_last(ft_eop, ft_last, 3'd0);
                  state_q      <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (data_ready_i) begin
                  first_q      <= 1'b0;
                  data_begin_q <= 1'b0;
                  if (cell_last) begin
                     data_valid_q  <= 1'b0;
                     data_end_q    <= 1'b0;
                     fl_free_req_q <= 1'b1;
                     fl_free_idx_q <= curr_idx_q;
                     state_q       <= S_FREE;
                  end else begin
                     beat_cnt_q <= beat_nxt;
                     data_q     <= beat_sel(payload_q, beat_nxt);
                     data_end_q <= eop_q && is_last(eop_q, last_beat_q, beat_nxt);
                  end
               end
            end
            S_FREE: begin
               if (fl_free_gnt_i) begin
                  fl_free_req_q <= 1'b0;
                  if (eop_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     curr_idx_q <= next_idx_q;
                     mem_addr_q <= next_idx_q;
                     mem_re_q   <= 1'b1;
                     state_q    <= S_READ;
                  end
               end
            end
            S_ERR:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_read_ctrl.sv
// Directed scoreboard bench for memory_read_ctrl: memory model on port B, expected
// beats and free indices queued at load time and popped as the DUT produces them.
module tb_memory_read_ctrl;

   localparam int ADDR_W     = 10;
   localparam int CELL_BEATS = 7;
   localparam int BLOCK_BITS = 64*CELL_BEATS + 64;

   typedef struct packed {
      logic [63:0] d;
      logic        b;
      logic        e;
   } exp_t;

   logic                  clk, rst_n;
   logic                  req_valid_i, req_ready_o;
   logic [ADDR_W-1:0]     req_head_idx_i;
   logic                  mem_re_o;
   logic [ADDR_W-1:0]     mem_addr_o;
   logic [BLOCK_BITS-1:0] mem_rdata_i;
   logic [63:0]           data_o;
   logic                  data_valid_o, data_begin_o, data_end_o, data_ready_i;
   logic                  fl_free_req_o, fl_free_gnt_i, err_o;
   logic [ADDR_W-1:0]     fl_free_idx_o;

   logic [BLOCK_BITS-1:0] mem [0:(1<<ADDR_W)-1];
   exp_t                  exp_q[$];
   logic [ADDR_W-1:0]     free_q[$];
   int                    checks = 0, failures = 0, err_cnt = 0;
   logic                  stall_q = 1'b0;
   logic [63:0]           hold_d;
   logic                  hold_b, hold_e;

   memory_read_ctrl #(.ADDR_W(ADDR_W), .CELL_BEATS(CELL_BEATS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_head_idx_i(req_head_idx_i), .req_ready_o(req_ready_o),
      .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
      .data_o(data_o), .data_valid_o(data_valid_o), .data_begin_o(data_begin_o),
      .data_end_o(data_end_o), .data_ready_i(data_ready_i),
      .fl_free_req_o(fl_free_req_o), .fl_free_idx_o(fl_free_idx_o),
      .fl_free_gnt_i(fl_free_gnt_i), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (mem_re_o) mem_rdata_i <= mem[mem_addr_o];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         exp_t       e;
         logic [ADDR_W-1:0] f;
         if (err_o) err_cnt++;
         if (stall_q) begin
            chk("hold_valid", 64'(data_valid_o), 64'd1);
            chk("hold_data", data_o, hold_d);
            chk("hold_begin", 64'(data_begin_o), 64'(hold_b));
            chk("hold_end", 64'(data_end_o), 64'(hold_e));
         end
         if (data_valid_o && data_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(data_valid_o), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", data_o, e.d);
               chk("beat_begin", 64'(data_begin_o), 64'(e.b));
               chk("beat_end", 64'(data_end_o), 64'(e.e));
            end
         end
         stall_q = data_valid_o && !data_ready_i;
         hold_d  = data_o;
         hold_b  = data_begin_o;
         hold_e  = data_end_o;
         if (fl_free_req_o && fl_free_gnt_i) begin
            if (free_q.size() == 0) begin
               chk("unexpected_free", 64'(fl_free_req_o), 64'd0);
            end else begin
               f = free_q.pop_front();
               chk("free_idx", 64'(fl_free_idx_o), 64'(f));
            end
         end
      end else begin
         stall_q = 1'b0;
      end
   end

   task automatic load_cell(input int idx, input int nxt, input bit eop, input bit vld,
                            input int lb, input int n_exp, input bit first, input bit push_free);
      logic [BLOCK_BITS-1:0] blk;
      logic [63:0]           b;
      exp_t                  e;
      blk = '0;
      for (int k = 0; k < CELL_BEATS; k++) begin
         b = {$urandom, $urandom};
         blk[BLOCK_BITS-1-64*k -: 64] = b;
         if (k < n_exp) begin
            e.d = b;
            e.b = first && (k == 0);
            e.e = eop && (k == n_exp-1);
            exp_q.push_back(e);
         end
      end
      blk[63:0]              = {$urandom, $urandom};
      blk[ADDR_W-1:0]        = ADDR_W'(nxt);
      blk[ADDR_W]            = eop;
      blk[ADDR_W+1]          = vld;
      blk[ADDR_W+4:ADDR_W+2] = 3'(lb);
      mem[idx] = blk;
      if (push_free) free_q.push_back(ADDR_W'(idx));
   endtask

   task automatic issue(input int h, input bit lat);
      @(posedge clk); #1;
      req_valid_i    = 1'b1;
      req_head_idx_i = ADDR_W'(h);
      @(negedge clk);
      chk("req_ready_idle", 64'(req_ready_o), 64'd1);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      if (lat) begin
         @(negedge clk);
         chk("lat_mem_re_T1", 64'(mem_re_o), 64'd1);
         chk("lat_mem_addr_T1", 64'(mem_addr_o), 64'(h));
         @(negedge clk);
         chk("lat_no_beat_T2", 64'(data_valid_o), 64'd0);
         @(negedge clk);
         chk("lat_beat_T3", 64'(data_valid_o), 64'd1);
      end
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!(req_ready_o && exp_q.size() == 0 && free_q.size() == 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(req_ready_o && exp_q.size() == 0 && free_q.size() == 0), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      rst_n = 1'b0; req_valid_i = 1'b0; req_head_idx_i = '0;
      data_ready_i = 1'b1; fl_free_gnt_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 64'(req_ready_o), 64'd1);
      chk("rst_mem_re", 64'(mem_re_o), 64'd0);
      chk("rst_data_valid", 64'(data_valid_o), 64'd0);
      chk("rst_outs", 64'({data_begin_o, data_end_o, fl_free_req_o, err_o}), 64'd0);
      chk("rst_addr_idx", 64'({mem_addr_o, fl_free_idx_o}), 64'd0);
      chk("rst_data", data_o, 64'd0);
      rst_n = 1'b1;

      // Single-cell packet, three beats.
      load_cell(5, 0, 1'b1, 1'b1, 2, 3, 1'b1, 1'b1);
      issue(5, 1'b1);
      wait_done("single_cell_done");

      // Two-cell chain 5 -> 9; last_beat on the non-eop cell must be ignored.
      load_cell(5, 9, 1'b0, 1'b1, 3, 7, 1'b1, 1'b1);
      load_cell(9, 0, 1'b1, 1'b1, 6, 7, 1'b0, 1'b1);
      issue(5, 1'b1);
      wait_done("chain_done");

      // Out-of-range last_beat is clamped to the final beat.
      load_cell(40, 0, 1'b1, 1'b1, 7, 7, 1'b1, 1'b1);
      issue(40, 1'b0);
      wait_done("clamp_done");

      // Backpressure: ready 1,0,0,1 starting at beat 0.
      load_cell(12, 0, 1'b1, 1'b1, 5, 6, 1'b1, 1'b1);
      issue(12, 1'b1);
      @(posedge clk); #1; data_ready_i = 1'b0;
      @(posedge clk); #1; data_ready_i = 1'b0;
      @(posedge clk); #1; data_ready_i = 1'b1;
      wait_done("backpressure_done");

      // Free-list stall on the first cell of a chain.
      load_cell(20, 21, 1'b0, 1'b1, 0, 7, 1'b1, 1'b1);
      load_cell(21, 0, 1'b1, 1'b1, 1, 2, 1'b0, 1'b1);
      fl_free_gnt_i = 1'b0;
      issue(20, 1'b0);
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!fl_free_req_o && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("stall_free_req_seen", 64'(fl_free_req_o), 64'd1);
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         chk("stall_req_held", 64'(fl_free_req_o), 64'd1);
         chk("stall_idx_held", 64'(fl_free_idx_o), 64'd20);
         chk("stall_no_read", 64'(mem_re_o), 64'd0);
         @(posedge clk); #1;
      end
      fl_free_gnt_i = 1'b1;
      wait_done("stall_done");

      // Footer with valid=0 on head 3.
      e0 = err_cnt;
`ifdef MEM_RD_FOOTER_CHECK_EN
      load_cell(3, 0, 1'b1, 1'b1, 2, 0, 1'b1, 1'b0);
      mem[3][ADDR_W+1] = 1'b0;
      issue(3, 1'b0);
      repeat (10) @(negedge clk);
      chk("corrupt_err_pulses", 64'(err_cnt - e0), 64'd1);
      chk("corrupt_idle", 64'(req_ready_o), 64'd1);
      chk("corrupt_no_beats", 64'(exp_q.size() + free_q.size()), 64'd0);
`else
      load_cell(3, 0, 1'b1, 1'b0, 2, 3, 1'b1, 1'b1);
      issue(3, 1'b1);
      wait_done("invalid_ignored_done");
      chk("invalid_no_err", 64'(err_cnt - e0), 64'd0);
`endif

      // Reset while beat 4 is on the bus.
      load_cell(30, 0, 1'b1, 1'b1, 6, 7, 1'b1, 1'b1);
      issue(30, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_beat4_valid", 64'(data_valid_o), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_data_valid", 64'(data_valid_o), 64'd0);
      chk("midrst_data", data_o, 64'd0);
      chk("midrst_outs", 64'({mem_re_o, data_begin_o, data_end_o, fl_free_req_o, err_o}), 64'd0);
      chk("midrst_addr_idx", 64'({mem_addr_o, fl_free_idx_o}), 64'd0);
      exp_q.delete();
      free_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_req_ready", 64'(req_ready_o), 64'd1);
      chk("postrst_no_free", 64'(fl_free_req_o), 64'd0);

      load_cell(31, 0, 1'b1, 1'b1, 1, 2, 1'b1, 1'b1);
      issue(31, 1'b1);
      wait_done("postrst_packet_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
